gray_code_counter: RTL and testbench



---
 rtl/gray_pkg.sv | 16 +
 rtl/binary_to_gray.sv | 14 +
 rtl/gray_code_counter.sv | 70 +++++++
 tb/tb_gray_code_counter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code pointer logic.
package gray_pkg;

  // Default pointer width used by the counter.
  localparam int GRAY_W = 4;

  // Widest pointer the helper function supports; narrower callers zero-extend
  // their input and truncate the result.
  localparam int GRAY_MAX_W = 32;

  // Reflected binary Gray code: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary-to-Gray mapping, any width up to GRAY_MAX_W.
module binary_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Upper zero-extension bits produce zeros in the Gray result, so truncation is exact.
  assign gray = WIDTH'(bin2gray(GRAY_MAX_W'(bin)));

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with a registered Gray-code copy for clock-domain crossing.
// The Gray value is derived from the next-state binary value, so both registers
// load on the same edge and gray_out always equals gray(bin_out).
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_nxt;

  // Next-state selection: load beats counting, counting beats hold; wrap only on a modular rollover.
  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    if (load) begin
      bin_nxt = load_bin;
    end else if (en) begin
      if (up_dn) begin
        bin_nxt  = bin_q + 1'b1;
        wrap_nxt = (bin_q == BIN_MAX);
      end else begin
        bin_nxt  = bin_q - 1'b1;
        wrap_nxt = (bin_q == '0);
      end
    end
  end

  binary_to_gray #(
    .WIDTH(WIDTH)
  ) u_bin2gray (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  // Binary, Gray and wrap registers share one edge and one synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= gray_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed self-checking bench for gray_code_counter (WIDTH = 4).
module tb_gray_code_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] bin_out;
  logic [W-1:0] gray_out;
  logic         wrap;

  int n_checks;
  int n_errors;

  // Scoreboard of expected gray values for the full up-count sweep.
  logic [W-1:0] exp_q[$];

  gray_code_counter #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .wrap     (wrap)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [W-1:0] lb);
    rst_n    = r;
    en       = e;
    up_dn    = u;
    load     = l;
    load_bin = lb;
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] b, input logic [W-1:0] g,
                            input logic w);
    check_val({tag, "_bin"}, 32'(bin_out), 32'(b));
    check_val({tag, "_gray"}, 32'(gray_out), 32'(g));
    check_val({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  logic [W-1:0] prev_gray;
  logic [W-1:0] exp_g;

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_q = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    // Reset held with load and en active.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h7);
    step();
    step();
    check_outs("reset", 4'h0, 4'h0, 1'b0);

    // Full up sweep from 0.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    prev_gray = gray_out;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_g = exp_q.pop_front();
      check_val($sformatf("up%0d_gray", i), 32'(gray_out), 32'(exp_g));
      check_val($sformatf("up%0d_bin", i), 32'(bin_out), 32'((i + 1) % 16));
      check_val($sformatf("up%0d_wrap", i), 32'(wrap), (i == 15) ? 32'd1 : 32'd0);
      check_val($sformatf("up%0d_hd", i), 32'($countones(gray_out ^ prev_gray)), 32'd1);
      prev_gray = gray_out;
    end

    // Down from 0 wraps to max, next step does not wrap.
    up_dn = 1'b0;
    step();
    check_outs("dn_wrap", 4'hF, 4'h8, 1'b1);
    check_val("dn_wrap_hd", 32'($countones(gray_out ^ prev_gray)), 32'd1);
    step();
    check_outs("dn_next", 4'hE, 4'h9, 1'b0);

    // Load wins over en/up_dn, then counting resumes from the loaded value.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hA);
    step();
    check_outs("load_a", 4'hA, 4'hF, 1'b0);
    load = 1'b0;
    step();
    check_outs("load_a_up", 4'hB, 4'hE, 1'b0);

    // Hold with wiggling inputs.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_dn    = ~up_dn;
      load_bin = 4'(i * 3);
      step();
      check_outs($sformatf("hold%0d", i), 4'hB, 4'hE, 1'b0);
    end

    // Loading max never wraps; the next up step does.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'hF);
    step();
    check_outs("load_max", 4'hF, 4'h8, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    check_outs("max_up", 4'h0, 4'h0, 1'b1);

    // Loading 0 never wraps either.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
    step();
    check_outs("load_zero", 4'h0, 4'h0, 1'b0);

    // Reset mid-count at 9 with en high.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'h9);
    step();
    check_outs("load_9", 4'h9, 4'hD, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h3);
    step();
    check_outs("mid_reset", 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    step();
    check_outs("post_reset_up", 4'h1, 4'h1, 1'b0);

    // Direction change between consecutive steps still moves one gray bit.
    prev_gray = gray_out;
    up_dn = 1'b0;
    step();
    check_outs("dir_change", 4'h0, 4'h0, 1'b0);
    check_val("dir_change_hd", 32'($countones(gray_out ^ prev_gray)), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
